// File: rtl/wb_timer_irq.sv
// Wishbone-mapped 32-bit timer with compare match, optional auto-reload,
// a sticky match flag and a maskable interrupt; low counter bits go to the pads.
module wb_timer_irq #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          IO_BITS   = 16
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    output logic [IO_BITS-1:0] io_out,
    output logic [IO_BITS-1:0] io_oeb,
    output logic               irq
);

    localparam logic [1:0] OFF_CTRL    = 2'd0;
    localparam logic [1:0] OFF_COUNT   = 2'd1;
    localparam logic [1:0] OFF_COMPARE = 2'd2;
    localparam logic [1:0] OFF_STATUS  = 2'd3;

    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        flag_q, flag_d;
    logic        irq_q, irq_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;

    logic        en, irq_en, auto_reload;
    logic        addr_hit, req, wr, match;
    logic [1:0]  off;
    logic [31:0] wmask;
    logic [31:0] rd_data;
    logic        unused_adr_bits;

    assign en          = ctrl_q[0];
    assign irq_en      = ctrl_q[1];
    assign auto_reload = ctrl_q[2];

    assign addr_hit = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign off      = wbs_adr_i[3:2];
    // Holding ack low for a cycle after every transfer gives the 2-cycle cadence.
    assign req      = wbs_stb_i & wbs_cyc_i & addr_hit & ~ack_q;
    assign wr       = req & wbs_we_i & (|wbs_sel_i);
    assign match    = en & (count_q == compare_q);

    assign unused_adr_bits = &{1'b0, wbs_adr_i[1:0]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wmask[8*gi +: 8] = {8{wbs_sel_i[gi]}};
        end
    endgenerate

    always_comb begin
        rd_data = '0;
        case (off)
            OFF_CTRL:    rd_data = {29'd0, ctrl_q};
            OFF_COUNT:   rd_data = count_q;
            OFF_COMPARE: rd_data = compare_q;
            OFF_STATUS:  rd_data = {31'd0, flag_q};
            default:     rd_data = '0;
        endcase
    end

    always_comb begin
        ctrl_d    = ctrl_q;
        count_d   = count_q;
        compare_d = compare_q;
        flag_d    = flag_q;

        if (en) begin
            count_d = (match && auto_reload) ? 32'd0 : count_q + 32'd1;
        end

        if (wr) begin
            case (off)
                OFF_CTRL: begin
                    if (wbs_sel_i[0]) begin
                        ctrl_d = wbs_dat_i[2:0];
                    end
                end
                OFF_COUNT:   count_d   = (count_q & ~wmask) | (wbs_dat_i & wmask);
                OFF_COMPARE: compare_d = (compare_q & ~wmask) | (wbs_dat_i & wmask);
                default: begin
                    if (wbs_sel_i[0] && wbs_dat_i[0]) begin
                        flag_d = 1'b0;
                    end
                end
            endcase
        end

        // A match on this cycle beats a simultaneous write-1-to-clear.
        if (match) begin
            flag_d = 1'b1;
        end
    end

    always_comb begin
        irq_d = flag_q & irq_en;
        ack_d = req;
        dat_d = (req && !wbs_we_i) ? rd_data : 32'd0;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ctrl_q    <= '0;
            count_q   <= '0;
            compare_q <= 32'hFFFF_FFFF;
            flag_q    <= 1'b0;
            irq_q     <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            flag_q    <= flag_d;
            irq_q     <= irq_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq       = irq_q;
    assign io_out    = count_q[IO_BITS-1:0];
    assign io_oeb    = '0;

endmodule
